// File: rtl/prll_bs_pkg.sv
// Shared definitions for the parallel-bus driver endpoint: ID field width,
// default broadcast address and the destination-ID extraction helper.
package prll_bs_pkg;

  localparam int unsigned     ID_W          = 8;
  localparam logic [ID_W-1:0] BROADCAST_DEF = 8'hFF;
  // Widest bus word the ID helper accepts; narrower words are zero-extended.
  localparam int unsigned     MAX_BITS      = 4096;

  // Destination ID occupies the top ID_W bits of a word_bits-wide bus word.
  function automatic logic [ID_W-1:0] id_field(input logic [MAX_BITS-1:0] word,
                                               input int unsigned word_bits);
    return word[word_bits-1 -: ID_W];
  endfunction

  function automatic logic id_match(input logic [ID_W-1:0] dst,
                                    input logic [ID_W-1:0] own_id,
                                    input logic [ID_W-1:0] bcast_id);
    return (dst == own_id) || (dst == bcast_id);
  endfunction

endpackage

// File: rtl/prll_bs_fifo_fwft.sv
// First-word-fall-through FIFO: head word is visible combinationally while not
// empty; a write on full is only taken when a read retires the head that cycle.
module prll_bs_fifo_fwft #(
  parameter int bits  = 256,
  parameter int depth = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [bits-1:0] wdata,
  input  logic            rd,
  output logic [bits-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int          AW      = $clog2(depth);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(depth);

  logic [bits-1:0] r_mem [depth];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_wr_ok;
  logic            w_rd_ok;

  assign empty   = (r_count == '0);
  assign full    = (r_count == C_DEPTH);
  assign w_rd_ok = rd && !empty;
  assign w_wr_ok = wr && (!full || rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale entries are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/prll_bs_drvr_endpoint.sv
// Driver-side bus endpoint: TX FIFO toward the bus, RX FIFO fed by pushes
// addressed to this endpoint or to broadcast, plus a saturating RX drop counter.
module prll_bs_drvr_endpoint
  import prll_bs_pkg::*;
#(
  parameter int              bits      = 256,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            pndng,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            tx_wr,
  input  logic [bits-1:0] tx_data,
  output logic            tx_full,
  input  logic            rx_rd,
  output logic [bits-1:0] rx_data,
  output logic            rx_empty,
  output logic [7:0]      rx_drop_cnt
);

  logic [MAX_BITS-1:0] w_push_ext;
  logic [ID_W-1:0]     w_dst;
  logic                w_match;
  logic                w_rx_wr;
  logic                w_rx_full;
  logic                w_tx_empty;
  logic                w_drop;
  logic [7:0]          r_drop_cnt;

  always_comb begin
    w_push_ext             = '0;
    w_push_ext[bits-1:0]   = D_push;
  end

  assign w_dst   = id_field(w_push_ext, bits);
  assign w_match = id_match(w_dst, id, broadcast);
  assign w_rx_wr = push && w_match;
  // A matching word is lost only when RX is full and nothing retires its head.
  assign w_drop  = w_rx_wr && w_rx_full && !rx_rd;

  prll_bs_fifo_fwft #(.bits(bits), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .full  (tx_full),
    .empty (w_tx_empty)
  );

  prll_bs_fifo_fwft #(.bits(bits), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (w_rx_wr),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (w_rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign pndng       = !w_tx_empty;
  assign rx_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_prll_bs_drvr_endpoint.sv
// Directed bench for prll_bs_drvr_endpoint (bits=256, depth=8, id=8'h03).
module tb_prll_bs_drvr_endpoint;

  localparam int BITS = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic            pndng;
  logic            pop;
  logic [BITS-1:0] D_pop;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            tx_wr;
  logic [BITS-1:0] tx_data;
  logic            tx_full;
  logic            rx_rd;
  logic [BITS-1:0] rx_data;
  logic            rx_empty;
  logic [7:0]      rx_drop_cnt;

  int checks = 0;
  int errors = 0;

  prll_bs_drvr_endpoint #(.bits(BITS), .depth(8), .id(8'h03), .broadcast(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .pop         (pop),
    .D_pop       (D_pop),
    .push        (push),
    .D_push      (D_push),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .rx_rd       (rx_rd),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BITS-1:0] mkw(input logic [7:0] dst, input int unsigned v);
    return {dst, 248'(v)};
  endfunction

  task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pop = 1'b0; push = 1'b0; D_push = '0;
    tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset held for three cycles, then released
    repeat (3) tick();
    chk("rst_pndng", 256'(pndng), 256'(1'b0));
    chk("rst_rx_empty", 256'(rx_empty), 256'(1'b1));
    chk("rst_D_pop", D_pop, '0);
    chk("rst_rx_data", rx_data, '0);
    reset = 1'b1;
    tick();
    chk("idle_pndng", 256'(pndng), 256'(1'b0));
    chk("idle_tx_full", 256'(tx_full), 256'(1'b0));
    chk("idle_rx_empty", 256'(rx_empty), 256'(1'b1));
    chk("idle_drop", 256'(rx_drop_cnt), 256'(8'd0));

    // TX fill 1..8, one-cycle write latency
    for (int i = 1; i <= 8; i++) begin
      tx_wr = 1'b1; tx_data = BITS'(i);
      tick();
      if (i == 1) begin
        chk("tx_first_pndng", 256'(pndng), 256'(1'b1));
        chk("tx_first_dpop", D_pop, 256'(1));
      end
      if (i == 7) chk("tx_7_not_full", 256'(tx_full), 256'(1'b0));
    end
    chk("tx_full_at_8", 256'(tx_full), 256'(1'b1));
    tx_data = BITS'(9);
    tick();
    tx_wr = 1'b0;
    chk("tx_over_full", 256'(tx_full), 256'(1'b1));
    chk("tx_over_head", D_pop, 256'(1));

    for (int i = 1; i <= 8; i++) begin
      chk("tx_pop_order", D_pop, 256'(i));
      pop = 1'b1;
      tick();
    end
    chk("tx_drained_pndng", 256'(pndng), 256'(1'b0));
    chk("tx_drained_dpop", D_pop, '0);
    tick();
    pop = 1'b0;
    chk("tx_pop_empty_pndng", 256'(pndng), 256'(1'b0));
    chk("tx_pop_empty_full", 256'(tx_full), 256'(1'b0));

    // Write+pop on an empty FIFO stores the word
    tx_wr = 1'b1; tx_data = BITS'(32'h55); pop = 1'b1;
    tick();
    tx_wr = 1'b0; pop = 1'b0;
    chk("tx_wrpop_empty_pndng", 256'(pndng), 256'(1'b1));
    chk("tx_wrpop_empty_dpop", D_pop, 256'(32'h55));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("tx_single_pop", 256'(pndng), 256'(1'b0));

    // Write+pop at full keeps count at depth, new word lands last
    for (int i = 0; i < 8; i++) begin
      tx_wr = 1'b1; tx_data = BITS'(32'h11 + i);
      tick();
    end
    tx_data = BITS'(32'hA1); pop = 1'b1;
    tick();
    tx_wr = 1'b0; pop = 1'b0;
    chk("tx_full_wrpop_full", 256'(tx_full), 256'(1'b1));
    chk("tx_full_wrpop_head", D_pop, 256'(32'h12));
    for (int i = 0; i < 7; i++) begin
      chk("tx_full_wrpop_order", D_pop, 256'(32'h12 + i));
      pop = 1'b1;
      tick();
    end
    chk("tx_a1_last", D_pop, 256'(32'hA1));
    tick();
    pop = 1'b0;
    chk("tx_a1_drained", 256'(pndng), 256'(1'b0));

    // RX address filter
    push = 1'b1; D_push = mkw(8'h03, 32'h100);
    tick();
    chk("rx_first_visible", 256'(rx_empty), 256'(1'b0));
    D_push = mkw(8'h05, 32'h200);
    tick();
    D_push = mkw(8'hFF, 32'h300);
    tick();
    push = 1'b0; D_push = '0;
    chk("rx_filt_head", rx_data, mkw(8'h03, 32'h100));
    rx_rd = 1'b1;
    tick();
    chk("rx_filt_second", rx_data, mkw(8'hFF, 32'h300));
    tick();
    chk("rx_filt_two_only", 256'(rx_empty), 256'(1'b1));
    tick();
    rx_rd = 1'b0;
    chk("rx_rd_empty", 256'(rx_empty), 256'(1'b1));
    chk("rx_filt_no_drop", 256'(rx_drop_cnt), 256'(8'd0));

    // RX overflow and drop counting
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = mkw(8'h03, 32'h10 + i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      D_push = mkw(8'h03, 32'hE0 + i);
      tick();
    end
    D_push = mkw(8'h05, 32'hEE);
    tick();
    chk("rx_drop_3", 256'(rx_drop_cnt), 256'(8'd3));
    chk("rx_over_head", rx_data, mkw(8'h03, 32'h10));
    D_push = mkw(8'h03, 32'hAB); rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    chk("rx_full_pushrd_drop", 256'(rx_drop_cnt), 256'(8'd3));
    chk("rx_full_pushrd_head", rx_data, mkw(8'h03, 32'h11));
    D_push = mkw(8'hFF, 32'hCC);
    repeat (300) tick();
    push = 1'b0; D_push = '0;
    chk("rx_drop_sat", 256'(rx_drop_cnt), 256'(8'd255));
    rx_rd = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("rx_over_contents", rx_data, mkw(8'h03, 32'h11 + i));
      tick();
    end
    chk("rx_pushrd_last", rx_data, mkw(8'h03, 32'hAB));
    tick();
    rx_rd = 1'b0;
    chk("rx_over_drained", 256'(rx_empty), 256'(1'b1));

    // Asynchronous reset mid-operation
    tx_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = BITS'(32'h40 + i);
      if (i < 2) begin
        push = 1'b1; D_push = mkw(8'h03, 32'h50 + i);
      end else begin
        push = 1'b0;
      end
      tick();
    end
    tx_wr = 1'b0; push = 1'b0; D_push = '0;
    chk("pre_rst_pndng", 256'(pndng), 256'(1'b1));
    chk("pre_rst_rx", 256'(rx_empty), 256'(1'b0));
    reset = 1'b0;
    #1;
    chk("async_rst_pndng", 256'(pndng), 256'(1'b0));
    chk("async_rst_rx_empty", 256'(rx_empty), 256'(1'b1));
    chk("async_rst_drop", 256'(rx_drop_cnt), 256'(8'd0));
    tick();
    reset = 1'b1;
    tx_wr = 1'b1; tx_data = BITS'(32'h77);
    tick();
    tx_wr = 1'b0;
    chk("post_rst_pndng", 256'(pndng), 256'(1'b1));
    chk("post_rst_dpop", D_pop, 256'(32'h77));
    chk("post_rst_rx_empty", 256'(rx_empty), 256'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
